// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master: FSM state
// encoding, sysid slave word addresses and a counter-width helper.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    CHECK   = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int bits;
    v = value - 1;
    bits = 0;
    while (v != 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read channel between the system-ID check master and the
// two-word system-ID slave.
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_check_master.sv
// Reads system ID and build timestamp from the sysid slave, compares them
// with build-time values and only then lets the stepper motors run.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h0400_0000,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'h5451_C2E7,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout_err,
  output logic                        motor_enable
);

  localparam int CNT_W   = clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic auto_start;
  logic launch, capture_id, capture_ts, expired, retry_now, fail_now;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An accepted request with readdatavalid in the same cycle skips WAIT.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture_id = 1'b0;
    capture_ts = 1'b0;
    expired    = 1'b0;
    retry_now  = 1'b0;
    fail_now   = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_start) begin
          launch     = 1'b1;
          state_next = REQ_ID;
        end
      end
      REQ_ID: begin
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            capture_id = 1'b1;
            state_next = REQ_TS;
          end else begin
            state_next = WAIT_ID;
          end
        end else if (cnt == CNT_LAST) begin
          expired = 1'b1;
        end
      end
      WAIT_ID: begin
        if (avm.avm_readdatavalid) begin
          capture_id = 1'b1;
          state_next = REQ_TS;
        end else if (cnt == CNT_LAST) begin
          expired = 1'b1;
        end
      end
      REQ_TS: begin
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            capture_ts = 1'b1;
            state_next = CHECK;
          end else begin
            state_next = WAIT_TS;
          end
        end else if (cnt == CNT_LAST) begin
          expired = 1'b1;
        end
      end
      WAIT_TS: begin
        if (avm.avm_readdatavalid) begin
          capture_ts = 1'b1;
          state_next = CHECK;
        end else if (cnt == CNT_LAST) begin
          expired = 1'b1;
        end
      end
      CHECK: state_next = IDLE;
      ERROR: begin
        if (start) begin
          launch     = 1'b1;
          state_next = REQ_ID;
        end
      end
      default: state_next = IDLE;
    endcase
    if (expired) begin
      if (retry < RETRY_MAX) begin
        retry_now  = 1'b1;
        state_next = REQ_ID;
      end else begin
        fail_now   = 1'b1;
        state_next = ERROR;
      end
    end
  end

  // Result flags persist after CHECK until the next sequence is launched.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      retry        <= '0;
      auto_start   <= 1'b1;
      id_value     <= '0;
      ts_value     <= '0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout_err  <= 1'b0;
      motor_enable <= 1'b0;
    end else begin
      auto_start <= 1'b0;
      done       <= 1'b0;
      if (launch || expired || capture_id || state == IDLE) begin
        cnt <= '0;
      end else if (busy && state != CHECK) begin
        cnt <= cnt + 1'b1;
      end
      if (launch) begin
        retry        <= '0;
        timeout_err  <= 1'b0;
        id_ok        <= 1'b0;
        ts_ok        <= 1'b0;
        motor_enable <= 1'b0;
      end
      if (retry_now) retry <= retry + 1'b1;
      if (fail_now) begin
        timeout_err  <= 1'b1;
        done         <= 1'b1;
        motor_enable <= 1'b0;
      end
      if (capture_id) id_value <= avm.avm_readdata;
      if (capture_ts) ts_value <= avm.avm_readdata;
      if (state == CHECK) begin
        id_ok        <= (id_value == EXP_ID);
        ts_ok        <= (ts_value == EXP_TIMESTAMP);
        motor_enable <= (id_value == EXP_ID) && (ts_value == EXP_TIMESTAMP) && !timeout_err;
        done         <= 1'b1;
      end
    end
  end

  assign busy            = (state != IDLE) && (state != ERROR);
  assign avm.avm_read    = (state == REQ_ID) || (state == REQ_TS);
  assign avm.avm_address = (state == REQ_TS || state == WAIT_TS) ? ADDR_TS : ADDR_ID;

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that sequences the two-word system-ID slave: word 0 is the system ID, word 1 is the build timestamp.
- Captures both words and compares them against build-time expected values.
- Gates the stepper-motor enable so motors run only on a verified hardware/software pairing.
- Sits beside the Nios/Qsys interconnect on the stepper-control subsystem clock.

Parameters:
- EXP_ID, 32'h04000000, expected system ID (word 0).
- EXP_TIMESTAMP, 32'h5451C2E7, expected build timestamp (word 1).
- TIMEOUT_CYCLES, 255, max cycles per read (request + response) before timeout; valid range 1..65535.
- MAX_RETRIES, 3, full-sequence retries after a timeout before the block enters ERROR.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; re-runs the check. Ignored while busy.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall; request holds while high.
- avm_readdatavalid  in  1  response strobe.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence (pass or fail).
- id_ok  out  1  id_value == EXP_ID.
- ts_ok  out  1  ts_value == EXP_TIMESTAMP.
- timeout_err  out  1  sticky; retries exhausted.
- motor_enable  out  1  id_ok & ts_ok & !timeout_err, registered.

Behaviour:
- Reset values: all outputs 0. State IDLE, retry count 0. Reset high on any cycle aborts an in-flight read and returns the block to these values next cycle.
- Auto-start: the first cycle after reset deasserts behaves as a start pulse.
- States and transitions:
  - IDLE: go to REQ_ID on start or auto-start. Clear id_ok, ts_ok, motor_enable. Timeout counter := 0.
  - REQ_ID: avm_read=1, avm_address=0. Leave when avm_waitrequest=0 that cycle -> WAIT_ID.
  - WAIT_ID: avm_read=0. On avm_readdatavalid: id_value <= avm_readdata -> REQ_TS.
  - REQ_TS / WAIT_TS: same as REQ_ID / WAIT_ID with address 1, capture into ts_value -> CHECK.
  - CHECK: register id_ok, ts_ok, motor_enable. Pulse done. -> IDLE.
  - ERROR: timeout_err=1, done pulsed on entry, motor_enable=0. Leave only on start, which clears timeout_err and retry count.
- Zero-wait-state path: with waitrequest=0 and readdatavalid asserted the cycle after the request, IDLE->CHECK takes 5 cycles and done is asserted 6 cycles after start.
- Readdatavalid in the same cycle as the accepted request (combinational slave) is accepted; the FSM skips WAIT and captures directly.
- Timeout counter: resets at each REQ entry and increments in REQ and WAIT states. On reaching TIMEOUT_CYCLES:
  - if retry count < MAX_RETRIES: increment retry count, restart at REQ_ID;
  - otherwise go to ERROR.
- Stray readdatavalid in IDLE, CHECK or ERROR is ignored.
- Busy = state not in {IDLE, ERROR}.
- Start while busy has no effect.
- id_value and ts_value hold their last captured values until overwritten.
- Mismatch is not an error state: done pulses, motor_enable=0, and ok flags show which word failed.

Decomposition:
- Package sysid_check_pkg: state enum (IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, ERROR), word address constants ADDR_ID=0 and ADDR_TS=1, and the counter width function clog2(TIMEOUT_CYCLES+1).
- No sub-module; the timeout counter stays inline.

Test Plan:
- Reset release, zero-wait slave returning 0x04000000 then 0x5451C2E7 -> done at cycle 6, id_ok=ts_ok=motor_enable=1, busy low after.
- Slave returns ID 0x04000001 -> done pulses, id_ok=0, ts_ok=1, motor_enable=0, timeout_err=0.
- waitrequest high 10 cycles on each read, readdatavalid 3 cycles later -> correct capture, no timeout, motor_enable=1.
- readdatavalid never asserted, TIMEOUT_CYCLES=8, MAX_RETRIES=2 -> 3 attempts with address returning to 0 each time, then ERROR, timeout_err=1, done one pulse; a subsequent start with a good slave -> timeout_err=0, motor_enable=1.
- reset asserted while in WAIT_TS -> next cycle all outputs 0; after release the sequence re-runs automatically.
- start pulsed during busy and stray readdatavalid in IDLE -> no state change, no extra done, id_value unchanged.
